vram_frame_arbiter: RTL and testbench

- Shares one single-port synchronous frame-buffer RAM between two requesters:
  - VGA scan-out reader: strict priority, never stalled.
  - Tracer pixel writer: uses leftover cycles, valid/ready handshake.
- Implements double buffering. Address MSB selects front or back buffer. The front buffer is swapped on tracer frame completion, aligned to VGA vblank.
- After each swap, an internal clear engine fills the new back buffer with CLEAR_COLOR before the tracer may write.
- Sits in top between the tracer core, the VGA timing/scan-out logic and the frame RAM.

---
 rtl/vram_frame_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_vram_frame_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_frame_arbiter.sv
// ============================================================================
// Module  : vram_frame_arbiter
// Brief   : Single-port frame RAM arbiter for VGA scan-out (strict priority)
//           and the tracer writer, with double buffering and back-buffer clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_frame_arbiter #(
    parameter int                PIX_AW      = 19,
    parameter int                NUM_PIXELS  = 307200,
    parameter int                DATA_W      = 12,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_rd_valid,
    input  logic [PIX_AW-1:0] vga_rd_addr,
    output logic [DATA_W-1:0] vga_rd_data,
    output logic              vga_rd_data_valid,
    input  logic              vblank,
    input  logic              tr_wr_valid,
    output logic              tr_wr_ready,
    input  logic [PIX_AW-1:0] tr_wr_addr,
    input  logic [DATA_W-1:0] tr_wr_data,
    input  logic              tr_frame_done,
    output logic              frame_ack,
    output logic              front_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [PIX_AW:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0]        ST_CLEAR     = 2'd0;
    localparam logic [1:0]        ST_RENDER    = 2'd1;
    localparam logic [1:0]        ST_SWAP_WAIT = 2'd2;
    localparam logic [PIX_AW-1:0] LAST_PIX     = PIX_AW'(NUM_PIXELS - 1);

    logic [1:0]        state_q, state_d;
    logic [PIX_AW-1:0] clr_cnt_q, clr_cnt_d;
    logic              swap_pend_q, swap_pend_d;
    logic              front_sel_q, front_sel_d;
    logic              frame_ack_q, frame_ack_d;
    logic              vblank_q;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [PIX_AW:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              rd_issue_q, rd_issue_d;
    logic              rd_ret_q, rd_ret_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              w_gnt_vga;
    logic              w_gnt_clr;
    logic              w_gnt_tr;
    logic              w_vblank_rise;
    logic              w_clr_last;

    assign w_vblank_rise = vblank && !vblank_q;
    assign w_clr_last    = (clr_cnt_q == LAST_PIX);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic (also owns counter, pending swap and front select)
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        swap_pend_d = swap_pend_q;
        front_sel_d = front_sel_q;
        frame_ack_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (tr_frame_done) begin
                    swap_pend_d = 1'b1;
                end
                // Counter only moves on cycles the clear actually owns the RAM.
                if (w_gnt_clr) begin
                    if (w_clr_last) begin
                        state_d     = (swap_pend_q || tr_frame_done) ? ST_SWAP_WAIT : ST_RENDER;
                        swap_pend_d = 1'b0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            ST_RENDER: begin
                if (tr_frame_done) begin
                    state_d = ST_SWAP_WAIT;
                end
            end
            ST_SWAP_WAIT: begin
                if (w_vblank_rise) begin
                    front_sel_d = ~front_sel_q;
                    frame_ack_d = 1'b1;
                    clr_cnt_d   = '0;
                    state_d     = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (slot grant and tracer handshake)
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt_vga   = vga_rd_valid;
        w_gnt_clr   = !vga_rd_valid && (state_q == ST_CLEAR);
        w_gnt_tr    = !vga_rd_valid && (state_q == ST_RENDER) && tr_wr_valid;
        tr_wr_ready = !vga_rd_valid && (state_q == ST_RENDER);
    end

    // ------------------------------------------------------------------------
    // RAM command and read-return pipeline
    // ------------------------------------------------------------------------
    always_comb begin
        mem_en_d    = w_gnt_vga || w_gnt_clr || w_gnt_tr;
        mem_we_d    = w_gnt_clr || w_gnt_tr;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (w_gnt_vga) begin
            // Reads use the front select as it stands this cycle, before any swap.
            mem_addr_d = {front_sel_q, vga_rd_addr};
        end else if (w_gnt_clr) begin
            mem_addr_d  = {~front_sel_q, clr_cnt_q};
            mem_wdata_d = CLEAR_COLOR;
        end else if (w_gnt_tr) begin
            mem_addr_d  = {~front_sel_q, tr_wr_addr};
            mem_wdata_d = tr_wr_data;
        end

        rd_issue_d = w_gnt_vga;
        rd_ret_d   = rd_issue_q;
        rd_valid_d = rd_ret_q;
        rd_data_d  = rd_ret_q ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt_q   <= '0;
            swap_pend_q <= 1'b0;
            front_sel_q <= 1'b0;
            frame_ack_q <= 1'b0;
            vblank_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_issue_q  <= 1'b0;
            rd_ret_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            clr_cnt_q   <= clr_cnt_d;
            swap_pend_q <= swap_pend_d;
            front_sel_q <= front_sel_d;
            frame_ack_q <= frame_ack_d;
            vblank_q    <= vblank;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_issue_q  <= rd_issue_d;
            rd_ret_q    <= rd_ret_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mem_en            = mem_en_q;
    assign mem_we            = mem_we_q;
    assign mem_addr          = mem_addr_q;
    assign mem_wdata         = mem_wdata_q;
    assign vga_rd_data       = rd_data_q;
    assign vga_rd_data_valid = rd_valid_q;
    assign frame_ack         = frame_ack_q;
    assign front_sel         = front_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_frame_arbiter.sv
// ============================================================================
// Module  : tb_vram_frame_arbiter
// Brief   : Directed + randomized bench for vram_frame_arbiter with a RAM
//           model and a frame-image reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_frame_arbiter;

    localparam int AW = 4;
    localparam int NP = 16;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_rd_valid;
    logic [AW-1:0] vga_rd_addr;
    logic [DW-1:0] vga_rd_data;
    logic          vga_rd_data_valid;
    logic          vblank;
    logic          tr_wr_valid;
    logic          tr_wr_ready;
    logic [AW-1:0] tr_wr_addr;
    logic [DW-1:0] tr_wr_data;
    logic          tr_frame_done;
    logic          frame_ack;
    logic          front_sel;
    logic          mem_en;
    logic          mem_we;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    vram_frame_arbiter #(
        .PIX_AW     (AW),
        .NUM_PIXELS (NP),
        .DATA_W     (DW),
        .CLEAR_COLOR(12'h000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .vga_rd_valid     (vga_rd_valid),
        .vga_rd_addr      (vga_rd_addr),
        .vga_rd_data      (vga_rd_data),
        .vga_rd_data_valid(vga_rd_data_valid),
        .vblank           (vblank),
        .tr_wr_valid      (tr_wr_valid),
        .tr_wr_ready      (tr_wr_ready),
        .tr_wr_addr       (tr_wr_addr),
        .tr_wr_data       (tr_wr_data),
        .tr_frame_done    (tr_frame_done),
        .frame_ack        (frame_ack),
        .front_sel        (front_sel),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    // Single-port synchronous RAM, with a bench-side preload port
    logic [DW-1:0] ram [2*NP];
    logic          poke_en;
    logic [AW:0]   poke_addr;
    logic [DW-1:0] poke_data;

    always @(posedge clk) begin
        if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference images of what the scan-out should see and what the tracer built
    logic [DW-1:0] img_front [NP];
    logic [DW-1:0] img_back  [NP];
    logic          rv  [3];
    logic [DW-1:0] rdx [3];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read returns must appear exactly three cycles after the request
    task automatic pipe_step(input logic req, input logic [DW-1:0] expd);
        chk("rd_valid_lat3", {31'd0, vga_rd_data_valid}, {31'd0, rv[2]});
        if (rv[2]) chk("rd_data", {20'd0, vga_rd_data}, {20'd0, rdx[2]});
        rv[2] = rv[1]; rdx[2] = rdx[1];
        rv[1] = rv[0]; rdx[1] = rdx[0];
        rv[0] = req;   rdx[0] = expd;
    endtask

    task automatic set_idle();
        vga_rd_valid  = 1'b0;
        vga_rd_addr   = '0;
        tr_wr_valid   = 1'b0;
        tr_wr_addr    = '0;
        tr_wr_data    = '0;
        tr_frame_done = 1'b0;
    endtask

    initial begin
        int k;
        logic          vr;
        logic [AW-1:0] va;
        logic [DW-1:0] tmp;

        rst = 1'b1;
        vblank = 1'b0;
        set_idle();
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        for (int i = 0; i < 3; i++) begin rv[i] = 1'b0; rdx[i] = '0; end

        // Preload the initial front buffer while the arbiter is held in reset
        for (int i = 0; i < NP; i++) begin
            img_front[i] = (i == 5) ? 12'hABC : DW'($urandom);
            img_back[i]  = 12'h000;
            poke_en = 1'b1; poke_addr = (AW+1)'(i); poke_data = img_front[i];
            tick();
        end
        poke_en = 1'b0;
        tick();

        chk("rst_mem_en", {31'd0, mem_en}, 0);
        chk("rst_front_sel", {31'd0, front_sel}, 0);
        chk("rst_tr_wr_ready", {31'd0, tr_wr_ready}, 0);
        chk("rst_rd_valid", {31'd0, vga_rd_data_valid}, 0);
        chk("rst_frame_ack", {31'd0, frame_ack}, 0);

        // Initial clear of buffer 1
        rst = 1'b0;
        for (int i = 0; i < NP; i++) begin
            tick();
            chk("clr1_we", {31'd0, mem_en & mem_we}, 1);
            chk("clr1_addr", {27'd0, mem_addr}, 32'(NP + i));
            chk("clr1_data", {20'd0, mem_wdata}, 0);
            chk("clr1_ready", {31'd0, tr_wr_ready}, (i == NP-1) ? 1 : 0);
        end
        tick();
        chk("idle_mem_en", {31'd0, mem_en}, 0);

        // Single read, latency 3
        vga_rd_valid = 1'b1; vga_rd_addr = 4'd5;
        tick();
        vga_rd_valid = 1'b0;
        chk("rd_n1_en", {31'd0, mem_en & ~mem_we}, 1);
        chk("rd_n1_addr", {27'd0, mem_addr}, 5);
        chk("rd_n1_valid", {31'd0, vga_rd_data_valid}, 0);
        tick();
        chk("rd_n2_valid", {31'd0, vga_rd_data_valid}, 0);
        tick();
        chk("rd_n3_valid", {31'd0, vga_rd_data_valid}, 1);
        chk("rd_n3_data", {20'd0, vga_rd_data}, 32'h0ABC);
        tick();
        chk("rd_n4_valid", {31'd0, vga_rd_data_valid}, 0);

        // VGA priority over a pending tracer write
        tr_wr_valid = 1'b1; tr_wr_addr = 4'd3; tr_wr_data = 12'hF00;
        vga_rd_valid = 1'b1; vga_rd_addr = 4'd7;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("contend_ready", {31'd0, tr_wr_ready}, 0);
            tick();
        end
        vga_rd_valid = 1'b0;
        #1;
        chk("contend_ready_free", {31'd0, tr_wr_ready}, 1);
        tick();
        tr_wr_valid = 1'b0;
        img_back[3] = 12'hF00;
        chk("contend_wr_we", {31'd0, mem_en & mem_we}, 1);
        chk("contend_wr_addr", {27'd0, mem_addr}, 19);
        chk("contend_wr_data", {20'd0, mem_wdata}, 32'h0F00);
        for (int i = 0; i < 5; i++) tick();

        // Randomized render traffic against the image model
        for (int c = 0; c < 80; c++) begin
            vr = ($urandom_range(0, 1) == 1);
            va = AW'($urandom_range(0, NP-1));
            vga_rd_valid = vr;
            vga_rd_addr  = va;
            tr_wr_valid  = ($urandom_range(0, 1) == 1);
            tr_wr_addr   = AW'($urandom_range(0, NP-1));
            tr_wr_data   = DW'($urandom);
            vblank       = ($urandom_range(0, 1) == 1);
            #1;
            chk("rand_ready", {31'd0, tr_wr_ready}, {31'd0, !vr});
            chk("rand_front", {31'd0, front_sel}, 0);
            chk("rand_ack", {31'd0, frame_ack}, 0);
            pipe_step(vr, img_front[va]);
            if (tr_wr_valid && !vr) img_back[tr_wr_addr] = tr_wr_data;
            tick();
        end
        set_idle();
        vblank = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            pipe_step(1'b0, '0);
            tick();
        end

        // Frame done, swap on a later vblank rise
        tr_frame_done = 1'b1;
        tick();
        tr_frame_done = 1'b0;
        tr_wr_valid = 1'b1; tr_wr_addr = 4'd1; tr_wr_data = 12'h0FF;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("swait_ready", {31'd0, tr_wr_ready}, 0);
            chk("swait_no_ack", {31'd0, frame_ack}, 0);
            tick();
            chk("swait_no_we", {31'd0, mem_we}, 0);
        end
        vblank = 1'b1;
        #1;
        chk("swait_ready_rise", {31'd0, tr_wr_ready}, 0);
        tick();
        tr_wr_valid = 1'b0;
        chk("swap_front", {31'd0, front_sel}, 1);
        chk("swap_ack", {31'd0, frame_ack}, 1);
        tick();
        chk("swap_ack_pulse", {31'd0, frame_ack}, 0);
        for (int i = 0; i < NP; i++) begin
            tmp = img_front[i]; img_front[i] = img_back[i]; img_back[i] = 12'h000;
        end
        k = 0;
        for (int c = 0; c < 40 && k < NP; c++) begin
            if (mem_en && mem_we) begin
                chk("clr0_addr", {27'd0, mem_addr}, 32'(k));
                chk("clr0_data", {20'd0, mem_wdata}, 0);
                k++;
            end
            if (k < NP) tick();
        end
        chk("clr0_count", 32'(k), NP);
        vblank = 1'b0;
        tick();

        // Read the new front buffer back end-to-end
        for (int j = 0; j < NP + 4; j++) begin
            vr = (j < NP);
            va = AW'(j % NP);
            vga_rd_valid = vr;
            vga_rd_addr  = va;
            #1;
            pipe_step(vr, img_front[va]);
            tick();
        end
        set_idle();

        // Second swap, then reset in the middle of the clear with a read in flight
        tr_frame_done = 1'b1;
        tick();
        tr_frame_done = 1'b0;
        vblank = 1'b1;
        tick();
        chk("swap2_front", {31'd0, front_sel}, 0);
        chk("swap2_ack", {31'd0, frame_ack}, 1);
        k = 0;
        for (int c = 0; c < 30 && k < 7; c++) begin
            tick();
            if (mem_en && mem_we) begin
                chk("clr1b_addr", {27'd0, mem_addr}, 32'(NP + k));
                k++;
            end
        end
        chk("clr1b_count", 32'(k), 7);
        vga_rd_valid = 1'b1; vga_rd_addr = 4'd2;
        tick();
        vga_rd_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mem_en", {31'd0, mem_en}, 0);
        chk("arst_mem_we", {31'd0, mem_we}, 0);
        chk("arst_mem_addr", {27'd0, mem_addr}, 0);
        chk("arst_mem_wdata", {20'd0, mem_wdata}, 0);
        chk("arst_rd_data", {20'd0, vga_rd_data}, 0);
        chk("arst_rd_valid", {31'd0, vga_rd_data_valid}, 0);
        chk("arst_front", {31'd0, front_sel}, 0);
        chk("arst_ack", {31'd0, frame_ack}, 0);
        chk("arst_ready", {31'd0, tr_wr_ready}, 0);
        tick();
        tick();
        rst = 1'b0;

        // Restarted clear, with a frame-done arriving mid-clear and vblank held high
        k = 0;
        for (int c = 0; c < 40 && k < NP; c++) begin
            tr_frame_done = (c == 2);
            tick();
            tr_frame_done = 1'b0;
            chk("pend_ready", {31'd0, tr_wr_ready}, 0);
            chk("pend_no_rd_valid", {31'd0, vga_rd_data_valid}, 0);
            if (mem_en && mem_we) begin
                chk("pend_clr_addr", {27'd0, mem_addr}, 32'(NP + k));
                k++;
            end
        end
        chk("pend_clr_count", 32'(k), NP);
        for (int i = 0; i < 10; i++) begin
            tr_wr_valid = 1'b1;
            tick();
            chk("pend_wait_ready", {31'd0, tr_wr_ready}, 0);
            chk("pend_wait_ack", {31'd0, frame_ack}, 0);
            chk("pend_wait_idle", {31'd0, mem_en}, 0);
        end
        tr_wr_valid = 1'b0;
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        chk("pend_swap_ack", {31'd0, frame_ack}, 1);
        chk("pend_swap_front", {31'd0, front_sel}, 1);
        tick();
        chk("pend_swap_ack_pulse", {31'd0, frame_ack}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
